mem_hazard: RTL and testbench
=============================

// Module: mem_hazard
// PURPOSE
//  MEM stage of the 5-stage RV32I pipeline. It consumes the EX/MEM register outputs, performs the data-memory
//  access over a req/ready bus and resolves branches (PCSrc). It stalls upstream while memory is busy.
//  It drives the MEM/WB register and memData_Out_MEMWB, the write-back value forwarded into EX (ForwardA/B = 01).
// PARAMETERS
//  DATA_W  32  data/address width
//  RD_W     5  register index width
// PORTS
//  clk                 in   1       rising-edge clock
//  rst_n               in   1       asynchronous active-low reset
//  PC_EXMEM            in   DATA_W  branch target from EX
//  read_Address_EXMEM  in   DATA_W  ALU result / memory address
//  write_Data_EXMEM    in   DATA_W  store data
//  rd_EXMEM            in   RD_W    destination register
//  branch_EXMEM, zero_EXMEM, memRead_EXMEM, memWrite_EXMEM, mem2reg_EXMEM, RegWrite_EXMEM  in 1  control bits
//  dmem_req            out  1       bus request
//  dmem_we             out  1       1 = write
//  dmem_addr           out  DATA_W  word address
//  dmem_wdata          out  DATA_W  store data
//  dmem_ready          in   1       access complete (rdata valid on reads)
//  dmem_rdata          in   DATA_W  load data
//  stall_MEM           out  1       freeze PC, IF/ID, ID/EX and EX/MEM
//  PCSrc               out  1       take branch (redirect PC to PC_EXMEM)
//  read_data_MEMWB     out  DATA_W  registered load data
//  alu_result_MEMWB    out  DATA_W  registered ALU result
//  rd_MEMWB            out  RD_W    registered destination
//  mem2reg_MEMWB, RegWrite_MEMWB  out 1  registered write-back control
//  memData_Out_MEMWB   out  DATA_W  mem2reg_MEMWB ? read_data_MEMWB : alu_result_MEMWB (combinational)
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE, every MEM/WB output is 0, dmem_req=0. An in-flight access is abandoned;
//    the bus must tolerate req dropping. memData_Out_MEMWB reads 0.
//  - access = memRead_EXMEM | memWrite_EXMEM. dmem_we = memWrite_EXMEM; a write wins if both are set.
//  - FSM IDLE: if access, go to BUSY with stall_MEM=1 and dmem_req=0 (one setup cycle). Otherwise the MEM/WB
//    register loads the EX/MEM values, and read_data_MEMWB keeps its previous value.
//  - FSM BUSY: dmem_req=1. addr, we and wdata are driven combinationally from the EX/MEM register, which
//    stall_MEM holds stable, so they stay stable until ready.
//    ready=0: stall_MEM=1, stay in BUSY. ready=1: stall_MEM=0, read_data_MEMWB<=dmem_rdata (reads only),
//    MEM/WB loads, go to IDLE.
//  - Minimum access latency 2 cycles (setup + ready-in-first-BUSY-cycle). A non-memory instruction takes 1 cycle.
//  - While stall_MEM=1 the MEM/WB register takes a bubble: RegWrite_MEMWB<=0, mem2reg_MEMWB<=0, data unchanged.
//    This prevents a duplicate write-back.
//  - Back-to-back accesses: after ready, IDLE sees the next EX/MEM contents and restarts the setup cycle.
//  - PCSrc = branch_EXMEM & zero_EXMEM & ~stall_MEM (combinational). The instruction after a branch cannot stall.
//  - Reset mid-BUSY: dmem_req falls asynchronously and there is no capture.
// CONFIGURATION
//  - MEM_ALIGN_CHECK_EN defined: adds output misalign_MEM (1 bit, reset 0).
//    If access and read_Address_EXMEM[1:0]!=0, there is no bus cycle, no stall and the FSM stays IDLE.
//    misalign_MEM pulses 1 on the next cycle, RegWrite_MEMWB<=0 and the instruction is dropped.
//  - Undefined: no alignment check, and the port does not exist. dmem_addr = {read_Address_EXMEM[31:2],2'b00}
//    in both cases.
// STRUCTURE
//  - rv_pipe_pkg: mem_state_t {IDLE, BUSY}, DATA_W/RD_W defaults, BUS_IDLE constants.
//  - Sub-module dmem_handshake: the FSM plus the dmem_req/stall_MEM/capture-enable logic.
//  - The top level holds the MEM/WB register, the PCSrc logic and the write-back mux.
// TESTING
//  - Non-memory op: RegWrite=1, rd=5, addr=0x1234 -> next cycle RegWrite_MEMWB=1, rd_MEMWB=5,
//    memData_Out_MEMWB=0x1234, stall_MEM never 1.
//  - Load, ready after 3 BUSY cycles, rdata=0xDEADBEEF, mem2reg=1 -> stall_MEM=1 for 4 cycles, RegWrite_MEMWB=0
//    meanwhile, then memData_Out_MEMWB=0xDEADBEEF.
//  - Store addr=0x40, data=0xA5A5A5A5, ready first BUSY cycle -> one req cycle with we=1, addr=0x40,
//    wdata=0xA5A5A5A5; RegWrite_MEMWB=0.
//  - Branch with zero=1 -> PCSrc=1 same cycle; zero=0 -> PCSrc=0.
//  - rst_n=0 during BUSY -> dmem_req=0 immediately, all MEM/WB outputs 0; after release, FSM IDLE.
//  - MEM_ALIGN_CHECK_EN, load addr=0x41 -> no dmem_req, misalign_MEM=1 for one cycle, RegWrite_MEMWB=0.

Source files
------------

// File: rtl/mem_hazard_pkg.sv
// Shared types and constants for the MEM stage and its data-memory handshake.
// The FSM state is a plain 1-bit logic type so older tools that lack enum support can still use it.
package mem_hazard_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_RD_W   = 5;

    typedef logic [0:0] mem_state_t;

    localparam mem_state_t IDLE = 1'b0;
    localparam mem_state_t BUSY = 1'b1;

    localparam logic BUS_IDLE_REQ = 1'b0;

endpackage

// File: rtl/mem_hazard_if.sv
// Data-memory request/ready bus. The MEM stage is the master and the memory is the slave.
interface mem_hazard_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/mem_hazard_dmem_handshake.sv
// Data-memory access FSM: spends one setup cycle, then holds req until ready,
// and tells the MEM/WB register when to load and when to capture read data.
module mem_hazard_dmem_handshake
    import mem_hazard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic access,
    input  logic misalign,
    input  logic ready,
    output logic req,
    output logic stall,
    output logic load,
    output logic done
);

    mem_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        req     = BUS_IDLE_REQ;
        stall   = 1'b0;
        load    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access && !misalign) begin
                    state_d = BUSY;
                    stall   = 1'b1;
                end else begin
                    // A misaligned access is dropped: MEM/WB takes a bubble instead
                    load = !misalign;
                end
            end
            BUSY: begin
                req = 1'b1;
                if (ready) begin
                    load    = 1'b1;
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/mem_hazard.sv
// MEM stage of the RV32I pipeline: data-memory access, branch resolution and the MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN adds misalign_MEM and drops misaligned accesses without a bus cycle.
module mem_hazard
    import mem_hazard_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_W   = DEF_RD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] PC_EXMEM,
    input  logic [DATA_W-1:0] read_Address_EXMEM,
    input  logic [DATA_W-1:0] write_Data_EXMEM,
    input  logic [RD_W-1:0]   rd_EXMEM,
    input  logic              branch_EXMEM,
    input  logic              zero_EXMEM,
    input  logic              memRead_EXMEM,
    input  logic              memWrite_EXMEM,
    input  logic              mem2reg_EXMEM,
    input  logic              RegWrite_EXMEM,
    mem_hazard_if.master      dmem,
    output logic              stall_MEM,
    output logic              PCSrc,
    output logic [DATA_W-1:0] read_data_MEMWB,
    output logic [DATA_W-1:0] alu_result_MEMWB,
    output logic [RD_W-1:0]   rd_MEMWB,
    output logic              mem2reg_MEMWB,
    output logic              RegWrite_MEMWB,
    output logic [DATA_W-1:0] memData_Out_MEMWB
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign_MEM
`endif
);

    logic access;
    logic misalign;
    logic load;
    logic done;
    logic is_read;

    assign access  = memRead_EXMEM | memWrite_EXMEM;
    // A write wins when both control bits are set, so only pure reads capture rdata
    assign is_read = memRead_EXMEM & ~memWrite_EXMEM;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = access & (read_Address_EXMEM[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    mem_hazard_dmem_handshake u_handshake (
        .clk      (clk),
        .rst_n    (rst_n),
        .access   (access),
        .misalign (misalign),
        .ready    (dmem.ready),
        .req      (dmem.req),
        .stall    (stall_MEM),
        .load     (load),
        .done     (done)
    );

    // EX/MEM is frozen by stall_MEM, so these stay stable for the whole access
    assign dmem.we    = memWrite_EXMEM;
    assign dmem.addr  = {read_Address_EXMEM[DATA_W-1:2], 2'b00};
    assign dmem.wdata = write_Data_EXMEM;

    assign PCSrc = branch_EXMEM & zero_EXMEM & ~stall_MEM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_MEMWB  <= '0;
            alu_result_MEMWB <= '0;
            rd_MEMWB         <= '0;
            mem2reg_MEMWB    <= 1'b0;
            RegWrite_MEMWB   <= 1'b0;
        end else if (load) begin
            alu_result_MEMWB <= read_Address_EXMEM;
            rd_MEMWB         <= rd_EXMEM;
            mem2reg_MEMWB    <= mem2reg_EXMEM;
            RegWrite_MEMWB   <= RegWrite_EXMEM;
            if (done && is_read) begin
                read_data_MEMWB <= dmem.rdata;
            end
        end else begin
            // Bubble: keep data, suppress write-back so the instruction retires only once
            mem2reg_MEMWB  <= 1'b0;
            RegWrite_MEMWB <= 1'b0;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_MEM <= 1'b0;
        end else begin
            misalign_MEM <= misalign;
        end
    end
`endif

    assign memData_Out_MEMWB = mem2reg_MEMWB ? read_data_MEMWB : alu_result_MEMWB;

endmodule

// File: tb/tb_mem_hazard.sv
// Self-checking bench for mem_hazard: directed scenarios then random instructions,
// each checked cycle by cycle against a transaction-level model of the MEM stage.
module tb_mem_hazard;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pc, addr_in, wdata_in;
    logic [RW-1:0] rd_in;
    logic          br, zr, mrd, mwr, m2r, rwr;
    logic          stall, pcsrc, m2r_wb, rw_wb;
    logic [DW-1:0] rdata_wb, alu_wb, mdo;
    logic [RW-1:0] rd_wb;
`ifdef MEM_ALIGN_CHECK_EN
    logic          mis_out;
`endif

    mem_hazard_if #(.DATA_W(DW)) dmem ();

    mem_hazard #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .PC_EXMEM           (pc),
        .read_Address_EXMEM (addr_in),
        .write_Data_EXMEM   (wdata_in),
        .rd_EXMEM           (rd_in),
        .branch_EXMEM       (br),
        .zero_EXMEM         (zr),
        .memRead_EXMEM      (mrd),
        .memWrite_EXMEM     (mwr),
        .mem2reg_EXMEM      (m2r),
        .RegWrite_EXMEM     (rwr),
        .dmem               (dmem),
        .stall_MEM          (stall),
        .PCSrc              (pcsrc),
        .read_data_MEMWB    (rdata_wb),
        .alu_result_MEMWB   (alu_wb),
        .rd_MEMWB           (rd_wb),
        .mem2reg_MEMWB      (m2r_wb),
        .RegWrite_MEMWB     (rw_wb),
        .memData_Out_MEMWB  (mdo)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign_MEM       (mis_out)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural view of the MEM/WB register
    logic [DW-1:0] m_rdata, m_alu;
    logic [RW-1:0] m_rd;
    logic          m_m2r, m_rw, m_mis;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rdata = '0; m_alu = '0; m_rd = '0; m_m2r = 1'b0; m_rw = 1'b0; m_mis = 1'b0;
    endtask

    task automatic chk_wb(input string tag);
        chk({tag, ".rw"},   {31'd0, rw_wb},  {31'd0, m_rw});
        chk({tag, ".m2r"},  {31'd0, m2r_wb}, {31'd0, m_m2r});
        chk({tag, ".rd"},   {27'd0, rd_wb},  {27'd0, m_rd});
        chk({tag, ".alu"},  alu_wb,   m_alu);
        chk({tag, ".rdat"}, rdata_wb, m_rdata);
        chk({tag, ".out"},  mdo, m_m2r ? m_rdata : m_alu);
`ifdef MEM_ALIGN_CHECK_EN
        chk({tag, ".mis"},  {31'd0, mis_out}, {31'd0, m_mis});
`endif
    endtask

    // Present one EX/MEM instruction (called #1 after a rising edge); the memory answers after lat wait cycles
    task automatic run_instr(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                             input logic [RW-1:0] rd, input logic b, input logic z,
                             input logic r, input logic w, input logic mr, input logic rw,
                             input int lat, input logic [DW-1:0] rdat);
        logic acc, mis, ok, exp_stall, exp_req;
        int   last;
        pc = $urandom; addr_in = a; wdata_in = wd; rd_in = rd;
        br = b; zr = z; mrd = r; mwr = w; m2r = mr; rwr = rw;
        acc = r | w;
`ifdef MEM_ALIGN_CHECK_EN
        mis = acc && (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        ok   = acc && !mis;
        last = ok ? lat + 1 : 0;
        for (int k = 0; k <= last; k++) begin
            dmem.ready = ok && (k == last);
            dmem.rdata = dmem.ready ? rdat : $urandom;
            @(negedge clk);
            exp_stall = ok && (k <= lat);
            exp_req   = ok && (k >= 1);
            chk({tag, ".stall"}, {31'd0, stall},     {31'd0, exp_stall});
            chk({tag, ".req"},   {31'd0, dmem.req},  {31'd0, exp_req});
            chk({tag, ".pcsrc"}, {31'd0, pcsrc},     {31'd0, b & z & ~exp_stall});
            if (exp_req) begin
                chk({tag, ".we"},    {31'd0, dmem.we}, {31'd0, w});
                chk({tag, ".addr"},  dmem.addr, {a[DW-1:2], 2'b00});
                chk({tag, ".wdata"}, dmem.wdata, wd);
            end
            if (exp_stall && k >= 1) begin
                chk({tag, ".bubble"}, {31'd0, rw_wb}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        dmem.ready = 1'b0;
        if (mis) begin
            m_rw = 1'b0; m_m2r = 1'b0;
        end else begin
            m_rd = rd; m_alu = a; m_m2r = mr; m_rw = rw;
            if (ok && r && !w) m_rdata = rdat;
        end
        m_mis = mis;
        chk_wb(tag);
    endtask

    initial begin
        pc = '0; addr_in = '0; wdata_in = '0; rd_in = '0;
        br = 0; zr = 0; mrd = 0; mwr = 0; m2r = 0; rwr = 0;
        dmem.ready = 1'b0; dmem.rdata = '0;
        model_reset();
        #12;
        chk("rst.req", {31'd0, dmem.req}, 32'd0);
        chk_wb("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_instr("nop_op", 32'h1234, 32'h0, 5'd5, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        run_instr("load3", 32'h100, 32'h0, 5'd7, 0, 0, 1, 0, 1, 1, 3, 32'hDEADBEEF);
        run_instr("store", 32'h40, 32'hA5A5A5A5, 5'd0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        run_instr("br_t", 32'h8, 32'h0, 5'd0, 1, 1, 0, 0, 0, 0, 0, 32'h0);
        run_instr("br_nt", 32'h8, 32'h0, 5'd0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        run_instr("rdwr", 32'h20, 32'h11112222, 5'd3, 0, 0, 1, 1, 1, 1, 0, 32'h77777777);
        run_instr("load0", 32'h24, 32'h0, 5'd9, 0, 0, 1, 0, 1, 1, 0, 32'hCAFEF00D);
        run_instr("alu_after", 32'h55AA, 32'h0, 5'd10, 0, 0, 0, 0, 0, 1, 0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        run_instr("misal", 32'h41, 32'h0, 5'd4, 0, 0, 1, 0, 1, 1, 0, 32'h12345678);
        run_instr("post_mis", 32'h44, 32'h0, 5'd4, 0, 0, 0, 0, 0, 1, 0, 32'h0);
`endif

        // Reset while BUSY: req must fall without waiting for a clock edge
        addr_in = 32'h80; mrd = 1; mwr = 0; m2r = 1; rwr = 1; rd_in = 5'd12; br = 0; zr = 0;
        dmem.ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstbusy.req_pre", {31'd0, dmem.req}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rstbusy.req", {31'd0, dmem.req}, 32'd0);
        chk_wb("rstbusy");
        mrd = 0; m2r = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_instr("after_rst", 32'h2468, 32'h0, 5'd1, 0, 0, 0, 0, 0, 1, 0, 32'h0);

        for (int i = 0; i < 150; i++) begin
            logic [DW-1:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_instr("rand", a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 4)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
